// File: rtl/ibex_rf_wport_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : ibex_rf_wport_arbiter
// Description : Register-file write-port arbiter. It runs a clear sweep after
//               reset or on request, then arbitrates core and debug writes
//               with an anti-starvation force for the debug port.
// Revision    : 1.0 - initial release
// ============================================================================
module ibex_rf_wport_arbiter #(
    parameter bit                   RV32E       = 1'b0,
    parameter int unsigned          DataWidth   = 32,
    parameter logic [DataWidth-1:0] WordZeroVal = '0,
    parameter int unsigned          MaxWait     = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 init_req_i,
    input  logic                 core_we_i,
    input  logic [4:0]           core_waddr_i,
    input  logic [DataWidth-1:0] core_wdata_i,
    output logic                 core_ready_o,
    input  logic                 dbg_req_i,
    input  logic [4:0]           dbg_waddr_i,
    input  logic [DataWidth-1:0] dbg_wdata_i,
    output logic                 dbg_gnt_o,
    output logic                 rf_we_o,
    output logic [4:0]           rf_waddr_o,
    output logic [DataWidth-1:0] rf_wdata_o,
    output logic                 init_done_o
);

    localparam int unsigned NUM_WORDS  = RV32E ? 16 : 32;
    localparam logic [4:0]  c_LAST_ADDR = 5'(NUM_WORDS - 1);
    localparam logic [3:0]  c_MAX_WAIT  = 4'(MaxWait);

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    state_e                 r_state;
    state_e                 w_state_next;
    logic [4:0]             r_sweep_cnt;
    logic [4:0]             w_sweep_next;
    logic [3:0]             r_wait_cnt;
    logic [3:0]             w_wait_next;
    logic                   w_force;
    logic                   w_core_ready;
    logic                   w_dbg_gnt;
    logic                   w_wr_en;
    logic [4:0]             w_wr_addr;
    logic [DataWidth-1:0]   w_wr_data;
    logic                   w_core_addr_ok;
    logic                   w_dbg_addr_ok;

    // Address 0 is hard-wired; in RV32E the upper half does not exist.
    generate
        if (RV32E) begin : g_rv32e
            assign w_core_addr_ok = (core_waddr_i != 5'd0) && !core_waddr_i[4];
            assign w_dbg_addr_ok  = (dbg_waddr_i  != 5'd0) && !dbg_waddr_i[4];
        end else begin : g_rv32i
            assign w_core_addr_ok = (core_waddr_i != 5'd0);
            assign w_dbg_addr_ok  = (dbg_waddr_i  != 5'd0);
        end
    endgenerate

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= ST_INIT;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_sweep_next = r_sweep_cnt;
        w_wait_next  = 4'd0;
        w_force      = 1'b0;
        w_core_ready = 1'b0;
        w_dbg_gnt    = 1'b0;
        w_wr_en      = 1'b0;
        w_wr_addr    = r_sweep_cnt;
        w_wr_data    = WordZeroVal;
        case (r_state)
            ST_INIT: begin
                w_wr_en      = 1'b1;
                w_sweep_next = r_sweep_cnt + 5'd1;
                if (r_sweep_cnt == c_LAST_ADDR) begin
                    w_state_next = ST_RUN;
                    w_sweep_next = 5'd1;
                end
            end
            ST_RUN: begin
                w_sweep_next = 5'd1;
                w_force      = (r_wait_cnt == c_MAX_WAIT);
                w_core_ready = !w_force;
                w_dbg_gnt    = dbg_req_i && (!core_we_i || w_force);
                if (core_we_i && w_core_ready) begin
                    w_wr_en   = w_core_addr_ok;
                    w_wr_addr = core_waddr_i;
                    w_wr_data = core_wdata_i;
                end else if (w_dbg_gnt) begin
                    w_wr_en   = w_dbg_addr_ok;
                    w_wr_addr = dbg_waddr_i;
                    w_wr_data = dbg_wdata_i;
                end
                // Saturate while blocked; at MaxWait the grant is forced anyway.
                if (dbg_req_i && !w_dbg_gnt) begin
                    w_wait_next = (r_wait_cnt == c_MAX_WAIT) ? r_wait_cnt : r_wait_cnt + 4'd1;
                end
                if (init_req_i) begin
                    w_state_next = ST_INIT;
                end
            end
            default: begin
                w_state_next = ST_INIT;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_sweep_cnt <= 5'd1;
            r_wait_cnt  <= 4'd0;
            rf_we_o     <= 1'b0;
            rf_waddr_o  <= 5'd0;
            rf_wdata_o  <= '0;
        end else begin
            r_sweep_cnt <= w_sweep_next;
            r_wait_cnt  <= w_wait_next;
            rf_we_o     <= w_wr_en;
            if (w_wr_en) begin
                rf_waddr_o <= w_wr_addr;
                rf_wdata_o <= w_wr_data;
            end
        end
    end

    assign core_ready_o = w_core_ready;
    assign dbg_gnt_o    = w_dbg_gnt;
    assign init_done_o  = (r_state == ST_RUN);

endmodule
`default_nettype wire

// File: tb/tb_ibex_rf_wport_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_ibex_rf_wport_arbiter
// Description : Directed self-checking bench for ibex_rf_wport_arbiter
//               (RV32I instance plus an RV32E instance on shared stimulus).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ibex_rf_wport_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        init_req = 1'b0;
    logic        core_we = 1'b0;
    logic [4:0]  core_waddr = 5'd0;
    logic [31:0] core_wdata = 32'd0;
    logic        dbg_req = 1'b0;
    logic [4:0]  dbg_waddr = 5'd0;
    logic [31:0] dbg_wdata = 32'd0;

    logic        core_ready, dbg_gnt, rf_we, init_done;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        e_core_ready, e_dbg_gnt, e_rf_we, e_init_done;
    logic [4:0]  e_rf_waddr;
    logic [31:0] e_rf_wdata;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    ibex_rf_wport_arbiter dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .init_req_i   (init_req),
        .core_we_i    (core_we),
        .core_waddr_i (core_waddr),
        .core_wdata_i (core_wdata),
        .core_ready_o (core_ready),
        .dbg_req_i    (dbg_req),
        .dbg_waddr_i  (dbg_waddr),
        .dbg_wdata_i  (dbg_wdata),
        .dbg_gnt_o    (dbg_gnt),
        .rf_we_o      (rf_we),
        .rf_waddr_o   (rf_waddr),
        .rf_wdata_o   (rf_wdata),
        .init_done_o  (init_done)
    );

    ibex_rf_wport_arbiter #(.RV32E(1'b1)) dut_e (
        .clk_i        (clk),
        .rst_i        (rst),
        .init_req_i   (init_req),
        .core_we_i    (core_we),
        .core_waddr_i (core_waddr),
        .core_wdata_i (core_wdata),
        .core_ready_o (e_core_ready),
        .dbg_req_i    (dbg_req),
        .dbg_waddr_i  (dbg_waddr),
        .dbg_wdata_i  (dbg_wdata),
        .dbg_gnt_o    (e_dbg_gnt),
        .rf_we_o      (e_rf_we),
        .rf_waddr_o   (e_rf_waddr),
        .rf_wdata_o   (e_rf_wdata),
        .init_done_o  (e_init_done)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_we",    32'(rf_we),      32'd0);
        chk("rst_waddr", 32'(rf_waddr),   32'd0);
        chk("rst_wdata", rf_wdata,        32'd0);
        chk("rst_done",  32'(init_done),  32'd0);
        chk("rst_ready", 32'(core_ready), 32'd0);
        chk("rst_gnt",   32'(dbg_gnt),    32'd0);
        rst = 1'b0;

        // Initial sweep: 31 writes (RV32I), 15 writes (RV32E)
        for (int i = 1; i <= 31; i++) begin
            tick();
            chk("sweep_we",    32'(rf_we),     32'd1);
            chk("sweep_waddr", 32'(rf_waddr),  32'(i));
            chk("sweep_wdata", rf_wdata,       32'd0);
            chk("sweep_done",  32'(init_done), (i == 31) ? 32'd1 : 32'd0);
            chk("e_sweep_we",    32'(e_rf_we),     (i <= 15) ? 32'd1 : 32'd0);
            chk("e_sweep_waddr", 32'(e_rf_waddr),  (i <= 15) ? 32'(i) : 32'd15);
            chk("e_sweep_done",  32'(e_init_done), (i >= 15) ? 32'd1 : 32'd0);
        end
        tick();
        chk("run_idle_we", 32'(rf_we), 32'd0);

        // Core write, addr 5
        core_we = 1'b1; core_waddr = 5'd5; core_wdata = 32'hDEADBEEF;
        #1;
        chk("core_ready", 32'(core_ready), 32'd1);
        chk("core_gnt0",  32'(dbg_gnt),    32'd0);
        tick();
        chk("core_we",    32'(rf_we),    32'd1);
        chk("core_waddr", 32'(rf_waddr), 32'd5);
        chk("core_wdata", rf_wdata,      32'hDEADBEEF);
        core_we = 1'b0; core_wdata = 32'h0;
        tick();
        chk("hold_we",    32'(rf_we),    32'd0);
        chk("hold_waddr", 32'(rf_waddr), 32'd5);
        chk("hold_wdata", rf_wdata,      32'hDEADBEEF);

        // Core write to address 0: acknowledged, not written
        core_we = 1'b1; core_waddr = 5'd0; core_wdata = 32'h00001234;
        #1;
        chk("z_ready", 32'(core_ready), 32'd1);
        tick();
        chk("z_we",    32'(rf_we),    32'd0);
        chk("z_waddr", 32'(rf_waddr), 32'd5);

        // Address 20: valid for RV32I, dropped by RV32E
        core_waddr = 5'd20; core_wdata = 32'hCAFEF00D;
        tick();
        chk("a20_we",     32'(rf_we),      32'd1);
        chk("a20_waddr",  32'(rf_waddr),   32'd20);
        chk("e_a20_we",   32'(e_rf_we),    32'd0);
        chk("e_a20_addr", 32'(e_rf_waddr), 32'd5);

        // Debug blocked by a busy core until wait count hits MaxWait
        core_waddr = 5'd3;
        dbg_req = 1'b1; dbg_waddr = 5'd9; dbg_wdata = 32'hA5A5A5A5;
        for (int k = 1; k <= 5; k++) begin
            core_wdata = 32'h11110000 + 32'(k);
            #1;
            chk("starve_gnt",   32'(dbg_gnt),    (k == 5) ? 32'd1 : 32'd0);
            chk("starve_ready", 32'(core_ready), (k == 5) ? 32'd0 : 32'd1);
            tick();
            chk("starve_we",    32'(rf_we),    32'd1);
            chk("starve_waddr", 32'(rf_waddr), (k == 5) ? 32'd9 : 32'd3);
            chk("starve_wdata", rf_wdata,      (k == 5) ? 32'hA5A5A5A5 : 32'h11110000 + 32'(k));
        end
        core_wdata = 32'h22222222;
        #1;
        chk("after_ready", 32'(core_ready), 32'd1);
        chk("after_gnt",   32'(dbg_gnt),    32'd0);
        tick();
        chk("after_waddr", 32'(rf_waddr), 32'd3);
        chk("after_wdata", rf_wdata,      32'h22222222);
        core_we = 1'b0; dbg_req = 1'b0;
        tick();

        // Debug write to address 0 with idle core
        dbg_req = 1'b1; dbg_waddr = 5'd0; dbg_wdata = 32'h0000FFFF;
        #1;
        chk("d0_gnt", 32'(dbg_gnt), 32'd1);
        tick();
        chk("d0_we",    32'(rf_we),    32'd0);
        chk("d0_waddr", 32'(rf_waddr), 32'd3);
        dbg_waddr = 5'd12; dbg_wdata = 32'h0C0C0C0C;
        #1;
        chk("d12_gnt", 32'(dbg_gnt), 32'd1);
        tick();
        chk("d12_we",    32'(rf_we),    32'd1);
        chk("d12_waddr", 32'(rf_waddr), 32'd12);
        chk("d12_wdata", rf_wdata,      32'h0C0C0C0C);
        dbg_req = 1'b0;

        // init request together with a core write
        core_we = 1'b1; core_waddr = 5'd7; core_wdata = 32'h00000077; init_req = 1'b1;
        #1;
        chk("ir_ready", 32'(core_ready), 32'd1);
        tick();
        chk("ir_we",    32'(rf_we),     32'd1);
        chk("ir_waddr", 32'(rf_waddr),  32'd7);
        chk("ir_wdata", rf_wdata,       32'h00000077);
        chk("ir_done",  32'(init_done), 32'd0);
        init_req = 1'b0; dbg_req = 1'b1; dbg_waddr = 5'd12;
        for (int i = 1; i <= 31; i++) begin
            #1;
            chk("isw_ready", 32'(core_ready), 32'd0);
            chk("isw_gnt",   32'(dbg_gnt),    32'd0);
            tick();
            chk("isw_we",    32'(rf_we),    32'd1);
            chk("isw_waddr", 32'(rf_waddr), 32'(i));
            chk("isw_wdata", rf_wdata,      32'd0);
        end
        core_we = 1'b0; dbg_req = 1'b0;
        chk("isw_done", 32'(init_done), 32'd1);
        tick();
        chk("isw_idle_we", 32'(rf_we), 32'd0);

        // Reset pulse in the middle of a sweep
        init_req = 1'b1;
        tick();
        init_req = 1'b0;
        chk("mr_ent_we", 32'(rf_we), 32'd0);
        for (int i = 1; i <= 9; i++) begin
            tick();
            chk("mr_waddr", 32'(rf_waddr), 32'(i));
        end
        rst = 1'b1;
        tick();
        chk("mr_rst_we",    32'(rf_we),     32'd0);
        chk("mr_rst_waddr", 32'(rf_waddr),  32'd0);
        chk("mr_rst_done",  32'(init_done), 32'd0);
        rst = 1'b0;
        tick();
        chk("mr_re_we",    32'(rf_we),    32'd1);
        chk("mr_re_waddr", 32'(rf_waddr), 32'd1);
        tick();
        chk("mr_re_waddr2", 32'(rf_waddr), 32'd2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
